fetch_queue_stage: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue, sitting between the instruction memory and the ID stage. It issues sequential fetch requests over a valid/ready port to a memory with variable, in-order latency. Returned instructions are buffered in a DEPTH-entry queue. Taken branches from EX redirect fetch and flush the queue, and stale in-flight responses are discarded. ID consumes one instruction per cycle unless it stalls.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_ibuf.sv | 110 +++++++++++
 rtl/fetch_queue_stage.sv | 127 ++++++++++++
 tb/tb_fetch_queue_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths and
// the canonical layout of one prefetch-queue entry.
package fetch_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int IBUF_DEPTH_DEF = 4;
    localparam int INSTR_W        = 32;

    // One prefetch-queue slot at the default address width.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [INSTR_W-1:0]  instr;
        logic                filled;
    } ibuf_entry_t;

endpackage

// File: rtl/fetch_ibuf.sv
// Circular prefetch buffer. Entries are allocated in request order at the
// tail, filled in response order, and consumed from the head. Pointers carry
// one extra wrap bit so a completely allocated-but-unfilled buffer is
// distinguishable from an empty one.
module fetch_ibuf
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = IBUF_DEPTH_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc_en,
    input  logic [XLEN-1:0]          alloc_pc,
    input  logic                     fill_en,
    input  logic [INSTR_W-1:0]       fill_data,
    input  logic                     pop_en,
    output logic [XLEN-1:0]          head_pc,
    output logic [INSTR_W-1:0]       head_instr,
    output logic                     head_filled,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   outstanding
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } entry_t;

    localparam entry_t         RESET_ENTRY = '{pc: RESET_PC, instr: {INSTR_W{1'b0}}, filled: 1'b0};
    localparam logic [PTR_W:0] PTR_ONE     = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0] PTR_ZERO    = {(PTR_W+1){1'b0}};

    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];
    logic [PTR_W:0]   alloc_q, alloc_d;
    logic [PTR_W:0]   fill_q,  fill_d;
    logic [PTR_W:0]   head_q,  head_d;
    logic [PTR_W-1:0] alloc_idx_s, fill_idx_s, head_idx_s;

    assign alloc_idx_s = alloc_q[PTR_W-1:0];
    assign fill_idx_s  = fill_q[PTR_W-1:0];
    assign head_idx_s  = head_q[PTR_W-1:0];

    // Next storage and pointer state: a flush discards everything, otherwise
    // alloc, fill and pop compose (a fill then pop of the same slot leaves it empty).
    always_comb begin
        entries_d = entries_q;
        alloc_d   = alloc_q;
        fill_d    = fill_q;
        head_d    = head_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].filled = 1'b0;
            end
            fill_d = alloc_q;
            head_d = alloc_q;
        end else begin
            if (alloc_en) begin
                entries_d[alloc_idx_s].pc     = alloc_pc;
                entries_d[alloc_idx_s].filled = 1'b0;
                alloc_d                       = alloc_q + PTR_ONE;
            end else begin
                alloc_d = alloc_q;
            end
            if (fill_en) begin
                entries_d[fill_idx_s].instr  = fill_data;
                entries_d[fill_idx_s].filled = 1'b1;
                fill_d                       = fill_q + PTR_ONE;
            end else begin
                fill_d = fill_q;
            end
            if (pop_en) begin
                entries_d[head_idx_s].filled = 1'b0;
                head_d                       = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
        end
    end

    // Storage and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= RESET_ENTRY;
            end
            alloc_q <= PTR_ZERO;
            fill_q  <= PTR_ZERO;
            head_q  <= PTR_ZERO;
        end else begin
            entries_q <= entries_d;
            alloc_q   <= alloc_d;
            fill_q    <= fill_d;
            head_q    <= head_d;
        end
    end

    assign head_pc     = entries_q[head_idx_s].pc;
    assign head_instr  = entries_q[head_idx_s].instr;
    assign head_filled = entries_q[head_idx_s].filled;
    assign count       = alloc_q - head_q;
    assign outstanding = alloc_q - fill_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage with prefetch queue. Issues sequential word fetches,
// buffers in-order responses, redirects on taken branches and discards the
// responses still in flight from the old path.
// Optional feature macro: IBUF_BYPASS_EN -- forwards a response straight to
// the ID outputs when it lands on an empty head slot, saving one cycle.
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = IBUF_DEPTH_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_take_branch,
    input  logic [XLEN-1:0]    ex_target_PC,
    input  logic               id_stall,
    output logic               imem_req_valid,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic [XLEN-1:0]    if_PC_out,
    output logic [XLEN-1:0]    if_NPC_out,
    output logic [INSTR_W-1:0] if_IR_out,
    output logic               if_valid_inst_out
);

    localparam int              CNT_W         = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_W       = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
    localparam logic [XLEN-1:0] PC_STEP       = XLEN'(3'd4);
    localparam logic [XLEN-1:0] RESET_PC_WORD = {RESET_PC[XLEN-1:2], 2'b00};

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]   count_s, outstanding_s;
    logic [CNT_W:0]     inflight_s;
    logic [XLEN-1:0]    head_pc_s;
    logic [INSTR_W-1:0] head_instr_s;
    logic               head_filled_s;
    logic               req_valid_s, accept_s, fill_en_s, pop_s, bypass_s, inst_valid_s;

    // Request gating, response routing and the ID-side pop decision.
    always_comb begin
        // Slots already promised: queued entries plus stale responses still to come.
        inflight_s = {1'b0, count_s} + {1'b0, drop_cnt_q};
        if (rst || ex_take_branch) begin
            req_valid_s = 1'b0;
        end else begin
            req_valid_s = (inflight_s < DEPTH_W);
        end
        accept_s = req_valid_s && imem_req_ready;
        if (imem_resp_valid && (drop_cnt_q == CNT_ZERO) && (outstanding_s != CNT_ZERO)) begin
            fill_en_s = 1'b1;
        end else begin
            fill_en_s = 1'b0;
        end
`ifdef IBUF_BYPASS_EN
        // An allocated but unfilled head is always the next slot to be filled.
        bypass_s = imem_resp_valid && (drop_cnt_q == CNT_ZERO) && (count_s != CNT_ZERO) && !head_filled_s;
`else
        bypass_s = 1'b0;
`endif
        inst_valid_s = !rst && (head_filled_s || bypass_s);
        pop_s        = inst_valid_s && !id_stall && !ex_take_branch;
    end

    // Next fetch address and count of stale responses to throw away.
    always_comb begin
        if (ex_take_branch) begin
            fetch_pc_d = ex_target_PC;
            drop_cnt_d = drop_cnt_q + outstanding_s - (imem_resp_valid ? CNT_ONE : CNT_ZERO);
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (imem_resp_valid && (drop_cnt_q != CNT_ZERO)) begin
                drop_cnt_d = drop_cnt_q - CNT_ONE;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // Fetch PC and drop counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= CNT_ZERO;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_ibuf #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC_WORD)
    ) u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .flush       (ex_take_branch),
        .alloc_en    (accept_s),
        .alloc_pc    (imem_req_addr),
        .fill_en     (fill_en_s),
        .fill_data   (imem_resp_data),
        .pop_en      (pop_s),
        .head_pc     (head_pc_s),
        .head_instr  (head_instr_s),
        .head_filled (head_filled_s),
        .count       (count_s),
        .outstanding (outstanding_s)
    );

    assign imem_req_valid    = req_valid_s;
    assign imem_req_addr     = {fetch_pc_q[XLEN-1:2], 2'b00};
    assign if_PC_out         = head_pc_s;
    assign if_NPC_out        = head_pc_s + PC_STEP;
    assign if_IR_out         = bypass_s ? imem_resp_data : head_instr_s;
    assign if_valid_inst_out = inst_valid_s;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: an in-order memory with fixed
// per-test latency, a queue-level reference model checked every cycle, and
// directed scenarios with hand-computed literal expectations.
module tb_fetch_queue_stage;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IBUF_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_take_branch;
    logic [31:0] ex_target_PC;
    logic        id_stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] if_PC_out;
    logic [31:0] if_NPC_out;
    logic [31:0] if_IR_out;
    logic        if_valid_inst_out;

    always #5 clk = ~clk;

    fetch_queue_stage dut (
        .clk               (clk),
        .rst               (rst),
        .ex_take_branch    (ex_take_branch),
        .ex_target_PC      (ex_target_PC),
        .id_stall          (id_stall),
        .imem_req_valid    (imem_req_valid),
        .imem_req_addr     (imem_req_addr),
        .imem_req_ready    (imem_req_ready),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .if_PC_out         (if_PC_out),
        .if_NPC_out        (if_NPC_out),
        .if_IR_out         (if_IR_out),
        .if_valid_inst_out (if_valid_inst_out)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_acc;
    mreq_t       mem_q [$];
    ibuf_entry_t mq [$];
    logic [31:0] m_pc;
    int          m_drop;
    logic [31:0] s_req, s_addr, s_valid, s_pc, s_npc, s_ir;
    logic [31:0] exp_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h00A0_0093;
        else return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, advance both.
    task automatic tick(input logic br, input logic [31:0] tgt, input logic stall, input logic rdy);
        logic        exp_req, exp_valid, head_filled, byp, resp, done;
        logic [31:0] exp_ir;
        int          outst;
        ibuf_entry_t e;
        ex_take_branch = br;
        ex_target_PC   = tgt;
        id_stall       = stall;
        imem_req_ready = rdy;
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0000_0000;
        end
        #1;
        resp        = imem_resp_valid;
        head_filled = (mq.size() > 0) && mq[0].filled;
        byp         = (BYP == 1) && (mq.size() > 0) && !head_filled && resp && (m_drop == 0);
        exp_req     = !rst && !br && ((mq.size() + m_drop) < DEPTH);
        exp_valid   = !rst && (head_filled || byp);
        s_req   = 32'(imem_req_valid);
        s_addr  = imem_req_addr;
        s_valid = 32'(if_valid_inst_out);
        s_pc    = if_PC_out;
        s_npc   = if_NPC_out;
        s_ir    = if_IR_out;
        chk("req_valid", s_req, 32'(exp_req));
        if (exp_req) chk("req_addr", s_addr, m_pc & 32'hFFFF_FFFC);
        chk("inst_valid", s_valid, 32'(exp_valid));
        if (exp_valid) begin
            exp_ir = byp ? imem_resp_data : mq[0].instr;
            chk("pc", s_pc, mq[0].pc);
            chk("npc", s_npc, mq[0].pc + 32'h4);
            chk("ir", s_ir, exp_ir);
        end
        if (rst) begin
            mem_q.delete();
            mq.delete();
            m_drop = 0;
            m_pc   = RESET_PC;
        end else begin
            if (resp) void'(mem_q.pop_front());
            if (imem_req_valid && rdy) mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
            if (br) begin
                outst = 0;
                foreach (mq[i]) if (!mq[i].filled) outst++;
                m_drop = m_drop + outst - (resp ? 1 : 0);
                mq.delete();
                m_pc = tgt;
            end else begin
                if (resp) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        done = 1'b0;
                        for (int i = 0; i < mq.size(); i++) begin
                            if (!done && !mq[i].filled) begin
                                e        = mq[i];
                                e.instr  = imem_resp_data;
                                e.filled = 1'b1;
                                mq[i]    = e;
                                done     = 1'b1;
                            end
                        end
                    end
                end
                if (exp_valid && !stall) void'(mq.pop_front());
                if (exp_req && rdy) begin
                    mq.push_back('{pc: m_pc & 32'hFFFF_FFFC, instr: 32'h0000_0000, filled: 1'b0});
                    m_pc = m_pc + 32'h4;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        chk("rst pc", s_pc, RESET_PC);
        chk("rst npc", s_npc, RESET_PC + 32'h4);
        chk("rst ir", s_ir, 32'h0000_0000);
        chk("rst valid", s_valid, 32'd0);
        chk("rst req", s_req, 32'd0);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst = 1'b1; ex_take_branch = 1'b0; ex_target_PC = 32'h0; id_stall = 1'b0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        m_pc = RESET_PC; m_drop = 0;
        @(posedge clk);
        #1;

        // A: latency 1, streaming one instruction per cycle
        lat = 1; do_reset();
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 32'h0, 1'b0, 1'b1);
            if (c == 0) begin
                chk("A first req", s_req, 32'd1);
                chk("A first addr", s_addr, 32'h0000_0000);
            end
            if (c >= 2 && c <= 7) begin
                exp_pc = 32'(4 * (c - 2 + BYP));
                chk("A valid", s_valid, 32'd1);
                chk("A pc", s_pc, exp_pc);
                chk("A npc", s_npc, exp_pc + 32'h4);
                chk("A ir", s_ir, mem_word(exp_pc));
            end
        end

        // B: ID stalled, queue fills to DEPTH then requests stop
        lat = 1; do_reset(); n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b1);
            if (s_req == 32'd1) n_acc++;
            if (c >= 2) begin
                chk("B stall valid", s_valid, 32'd1);
                chk("B stall pc", s_pc, 32'h0000_0000);
            end
        end
        chk("B accepts", 32'(n_acc), 32'd4);
        chk("B req low", s_req, 32'd0);
        for (int c = 10; c < 20; c++) begin
            tick(1'b0, 32'h0, 1'b0, 1'b1);
            if (c == 10) chk("B release pc", s_pc, 32'h0000_0000);
            if (c == 11) chk("B next pc", s_pc, 32'h0000_0004);
        end

        // C: latency 3, redirect to 0x100 with three requests in flight
        lat = 3; do_reset();
        for (int c = 0; c < 16; c++) begin
            tick(c == 3, 32'h0000_0100, 1'b0, 1'b1);
            if (c == 3) begin
                chk("C redirect req", s_req, 32'd0);
                chk("C model drop", 32'(m_drop), 32'd2);
            end
            if (c >= 4 && c <= 7 - BYP) chk("C stale valid", s_valid, 32'd0);
            if (c == 8 - BYP) begin
                chk("C target valid", s_valid, 32'd1);
                chk("C target pc", s_pc, 32'h0000_0100);
                chk("C target ir", s_ir, 32'hDEAD_0100);
            end
        end

        // D: redirect coinciding with a stale response, one more outstanding
        lat = 2; do_reset();
        for (int c = 0; c < 12; c++) begin
            tick(c == 2, 32'h0000_0300, 1'b0, c != 2);
            if (c == 2) begin
                chk("D redirect req", s_req, 32'd0);
                chk("D model drop", 32'(m_drop), 32'd1);
            end
            if (c >= 3 && c <= 5 - BYP) chk("D stale valid", s_valid, 32'd0);
            if (c == 6 - BYP) begin
                chk("D target pc", s_pc, 32'h0000_0300);
                chk("D target ir", s_ir, 32'hDEAD_0300);
            end
        end

        // E: memory not ready for five cycles
        lat = 1; do_reset();
        for (int c = 0; c < 11; c++) begin
            tick(1'b0, 32'h0, 1'b0, c >= 5);
            if (c < 5) begin
                chk("E hold req", s_req, 32'd1);
                chk("E hold addr", s_addr, 32'h0000_0000);
                chk("E no inst", s_valid, 32'd0);
            end
            if (c == 7 - BYP) begin
                chk("E first valid", s_valid, 32'd1);
                chk("E first pc", s_pc, 32'h0000_0000);
            end
        end

        // F: empty queue, response 0x00A00093 lands at cycle 2
        lat = 1; do_reset();
        for (int c = 0; c < 7; c++) begin
            tick(c == 0, 32'h0000_0200, 1'b0, 1'b1);
            if (c == 2) chk("F valid at N", s_valid, 32'(BYP));
            if (c == 3 - BYP) begin
                chk("F pc", s_pc, 32'h0000_0200);
                chk("F ir", s_ir, 32'h00A0_0093);
            end
        end

        // G: unaligned redirect near the top of the address space wraps
        lat = 1; do_reset();
        for (int c = 0; c < 8; c++) begin
            tick(c == 0, 32'hFFFF_FFFE, 1'b0, 1'b1);
            if (c == 1) chk("G addr top", s_addr, 32'hFFFF_FFFC);
            if (c == 2) chk("G addr wrap", s_addr, 32'h0000_0000);
            if (c == 3 - BYP) begin
                chk("G pc top", s_pc, 32'hFFFF_FFFC);
                chk("G npc wrap", s_npc, 32'h0000_0000);
            end
            if (c == 4 - BYP) chk("G pc wrapped", s_pc, 32'h0000_0000);
        end

        // H: reset right after a redirect clears pending drops
        lat = 3; do_reset();
        for (int c = 0; c < 4; c++) tick(c == 3, 32'h0000_0100, 1'b0, 1'b1);
        rst = 1'b1;
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        chk("H rst req", s_req, 32'd0);
        chk("H rst valid", s_valid, 32'd0);
        rst = 1'b0; cyc = 0; lat = 1;
        for (int c = 0; c < 8; c++) begin
            tick(1'b0, 32'h0, 1'b0, 1'b1);
            if (c == 2 - BYP) begin
                chk("H valid", s_valid, 32'd1);
                chk("H pc", s_pc, 32'h0000_0000);
                chk("H ir", s_ir, 32'hDEAD_0000);
            end
            if (c == 3 - BYP) chk("H pc next", s_pc, 32'h0000_0004);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
